// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-add cell, LSB first, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_a, fa_b, fa_sum, fa_carry;

  // The single time-shared full-add cell.
  always_comb begin
    fa_a     = a_sh_q[0];
    fa_b     = b_sh_q[0];
    fa_sum   = fa_a ^ fa_b ^ carry_q;
    fa_carry = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          s_sh_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = {fa_sum, s_sh_q[WIDTH-1:1]};
        carry_d = fa_carry;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          sum_d   = {fa_sum, s_sh_q[WIDTH-1:1]};
          c_out_d = fa_carry;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB during the last bit.
          ovf_d   = carry_q ^ fa_carry;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized bench for serial_adder_ctrl against a plain-arithmetic model.
// Define SERIAL_ADD_OVF_EN to also check the overflow output.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, c_in;
  logic         out_valid, out_ready, c_out, busy;
  logic [W-1:0] a, b, sum;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = -1;
  int prev_stall = 0;
  logic [W-1:0] prev_sum;
  logic         prev_c;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .busy(busy)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic oc, input int stall, input bit noise);
    logic [W:0] exp;
    longint     sa, sb, ss;
    logic       exp_ovf;
    int         n;
    exp = {1'b0, oa} + {1'b0, ob} + (W+1)'(oc);
    sa  = oa[W-1] ? longint'(oa) - (longint'(1) << W) : longint'(oa);
    sb  = ob[W-1] ? longint'(ob) - (longint'(1) << W) : longint'(ob);
    ss  = sa + sb + longint'(oc);
    exp_ovf = (ss > (longint'(1) << (W-1)) - 1) || (ss < -(longint'(1) << (W-1)));
    n = 0;
    while (!in_ready && n < 50) begin step; n++; end
    chk("idle_in_ready", in_ready, 1);
    a = oa; b = ob; c_in = oc; in_valid = 1'b1;
    out_ready = (stall == 0);
    step;
    if (last_acc >= 0) chk("issue_gap", cyc - last_acc, W + 2 + prev_stall);
    last_acc = cyc;
    prev_stall = stall;
    n = 0;
    while (!out_valid && n < 3*W) begin
      chk("run_in_ready", in_ready, 0);
      chk("run_busy", busy, 1);
      chk("run_sum_hold", sum, prev_sum);
      chk("run_cout_hold", c_out, prev_c);
      if (noise) begin
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      step;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, W);
    chk("sum", sum, exp[W-1:0]);
    chk("c_out", c_out, exp[W]);
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf", ovf, exp_ovf);
`endif
    chk("done_busy", busy, 1);
    chk("done_in_ready", in_ready, 0);
    for (int s = 0; s < stall; s++) begin
      step;
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", sum, exp[W-1:0]);
      chk("stall_cout", c_out, exp[W]);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_sum_hold", sum, exp[W-1:0]);
    prev_sum = exp[W-1:0];
    prev_c   = exp[W];
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0;
    prev_sum = '0; prev_c = 1'b0;
    repeat (3) step;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", c_out, 0);

    run_op(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 5, 1'b0);
    run_op(8'h12, 8'h34, 1'b1, 0, 1'b1);
    run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'h80, 8'hFF, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);

    a = 8'hC3; b = 8'h77; c_in = 1'b1; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    repeat (3) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", c_out, 0);
    prev_sum = '0; prev_c = 1'b0;
    last_acc = -1;
    run_op(8'h10, 8'h20, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
